// File: rtl/decoder_nxm_seq_pkg.sv
// Shared types and helpers for the decoder_nxm_seq one-hot decoder.
package decoder_pkg;

  localparam int MAX_SEL_W = 5;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_e;

  // Widest decode supported; callers cast down to their own SEL_W/OUT_W.
  function automatic logic [2**MAX_SEL_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [2**MAX_SEL_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nxm_seq_if.sv
// Handshake and decode bus between control logic (master) and decoder_nxm_seq (slave).
interface decoder_nxm_seq_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 2**SEL_W;

  logic               en;
  logic               mode;
  logic               in_valid;
  logic [SEL_W-1:0]   in;
  logic               in_ready;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic [SEL_W-1:0]   code;
  logic               scan_wrap;

  modport master (
    output en, mode, in_valid, in, dwell,
    input  in_ready, out, out_valid, code, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, in, dwell,
    output in_ready, out, out_valid, code, scan_wrap
  );

endinterface

// File: rtl/decoder_nxm_seq_dwell_timer.sv
// Down-counter that ticks when it reaches zero and reloads from load_val on tick or load.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - DWELL_W'(1);
    if (load || tick) cnt_d = load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_nxm_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with valid/ready input.
// Define DEC_SCAN_EN to build the auto-scan mode with programmable dwell.
module decoder_nxm_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  decoder_nxm_seq_if.slave bus
);

  localparam int OUT_W = 2**SEL_W;

  state_e           state_q;
  logic [SEL_W-1:0] code_q;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic             accept;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] sel);
    return OUT_W'(onehot(MAX_SEL_W'(sel)));
  endfunction

`ifdef DEC_SCAN_EN
  logic             scan_enter;
  logic             tick;
  logic             scan_wrap_q;
  logic [SEL_W-1:0] code_inc;

  assign scan_enter    = bus.en && (bus.mode == MODE_SCAN) && (state_q != SCAN);
  assign bus.in_ready  = bus.en && (bus.mode == MODE_DIRECT) && (state_q != SCAN);
  assign bus.scan_wrap = scan_wrap_q;
  assign code_inc      = code_q + SEL_W'(1);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (scan_enter),
    .load_val (bus.dwell),
    .tick     (tick)
  );
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{bus.mode, bus.dwell};
  assign bus.in_ready       = bus.en;
  assign bus.scan_wrap      = 1'b0;
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.code      = code_q;

  // Priority: disable, then scan stepping/exit, then scan entry, then direct accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef DEC_SCAN_EN
      scan_wrap_q <= 1'b0;
`endif
    end else begin
`ifdef DEC_SCAN_EN
      scan_wrap_q <= 1'b0;
`endif
      if (!bus.en) begin
        state_q     <= IDLE;
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
`ifdef DEC_SCAN_EN
      else if (state_q == SCAN) begin
        if (bus.mode == MODE_DIRECT) begin
          state_q <= HOLD;
        end else if (tick) begin
          code_q      <= code_inc;
          out_q       <= dec(code_inc);
          scan_wrap_q <= &code_q;
        end
      end else if (scan_enter) begin
        state_q     <= SCAN;
        code_q      <= '0;
        out_q       <= OUT_W'(1);
        out_valid_q <= 1'b1;
      end
`endif
      else if (accept) begin
        state_q     <= HOLD;
        code_q      <= bus.in;
        out_q       <= dec(bus.in);
        out_valid_q <= 1'b1;
      end
    end
  end

endmodule
